// File: rtl/jt49_pkg.sv
// Shared constants, types and LFSR step function for the JT49 noise path.
package jt49_pkg;

  localparam int JT49_LFSR_W = 17;
  localparam int JT49_TAP0   = 0;
  localparam int JT49_TAP1   = 3;
  localparam int JT49_PER_W  = 5;

  typedef logic [JT49_LFSR_W-1:0] jt49_poly_t;

  typedef enum logic {
    RS_IDLE,
    RS_ACK
  } jt49_rs_state_e;

  // The all-zero term lets a cleared register start itself.
  function automatic jt49_poly_t jt49_lfsr_step(input jt49_poly_t poly);
    return {poly[JT49_TAP0] ^ poly[JT49_TAP1] ^ (poly == '0), poly[JT49_LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/jt49_noise_lane.sv
// Combinational next-state of one noise voice: divider, LFSR step, reseed.
module jt49_noise_lane
  import jt49_pkg::*;
(
  input  logic [JT49_PER_W-1:0] count,
  input  logic                  div,
  input  jt49_poly_t            poly,
  input  logic [JT49_PER_W-1:0] period,
  input  logic                  reseed,
  output logic [JT49_PER_W-1:0] count_nx,
  output logic                  div_nx,
  output jt49_poly_t            poly_nx,
  output logic                  noise_nx
);

  logic [JT49_PER_W:0] eff_per;
  logic [JT49_PER_W:0] count_inc;

  always_comb begin
    eff_per   = (period == '0) ? (JT49_PER_W+1)'(1) : {1'b0, period};
    count_inc = {1'b0, count} + (JT49_PER_W+1)'(1);
    count_nx  = count_inc[JT49_PER_W-1:0];
    div_nx    = div;
    poly_nx   = poly;
    noise_nx  = ~poly[0];

    // >= so a period shrunk below the running count ends on this slot
    if (count_inc >= eff_per) begin
      count_nx = '0;
      div_nx   = ~div;
    end

    if (!div && div_nx)
      poly_nx = jt49_lfsr_step(poly);

    if (reseed) begin
      count_nx = '0;
      div_nx   = 1'b0;
      poly_nx  = '0;
    end
  end

endmodule

// File: rtl/jt49_noise_sched.sv
// Round-robin scheduler running NCH noise voices through one shared lane,
// with a req/ack reseed handshake.
module jt49_noise_sched
  import jt49_pkg::*;
#(
  parameter int NCH = 3,
  parameter int SW  = $clog2(NCH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen,
  input  logic [JT49_PER_W*NCH-1:0] period,
  input  logic                      reseed_req,
  input  logic [SW-1:0]             reseed_voice,
  output logic                      reseed_ack,
  output logic [NCH-1:0]            noise
);

  logic [SW-1:0]         sel;
  logic [JT49_PER_W-1:0] count [NCH];
  logic [NCH-1:0]        div;
  jt49_poly_t            poly  [NCH];

  jt49_rs_state_e rs_state, rs_next;

  logic [JT49_PER_W-1:0] cur_count, cur_period, nx_count;
  logic                  cur_div, nx_div, nx_noise;
  jt49_poly_t            cur_poly, nx_poly;
  logic                  voice_ok, reseed_hit, lane_reseed;

  always_comb begin
    cur_count  = '0;
    cur_div    = 1'b0;
    cur_poly   = '0;
    cur_period = '0;
    for (int unsigned v = 0; v < NCH; v++) begin
      if (sel == SW'(v)) begin
        cur_count  = count[v];
        cur_div    = div[v];
        cur_poly   = poly[v];
        cur_period = period[JT49_PER_W*v +: JT49_PER_W];
      end
    end
  end

  // Out-of-range voices are acknowledged on the next cen without touching state.
  always_comb begin
    voice_ok    = int'(reseed_voice) < NCH;
    reseed_hit  = cen && reseed_req && (rs_state == RS_IDLE) &&
                  (!voice_ok || reseed_voice == sel);
    lane_reseed = reseed_hit && voice_ok;
  end

  jt49_noise_lane u_lane (
    .count    (cur_count),
    .div      (cur_div),
    .poly     (cur_poly),
    .period   (cur_period),
    .reseed   (lane_reseed),
    .count_nx (nx_count),
    .div_nx   (nx_div),
    .poly_nx  (nx_poly),
    .noise_nx (nx_noise)
  );

  always_comb begin
    rs_next = rs_state;
    case (rs_state)
      RS_IDLE: if (reseed_hit) rs_next = RS_ACK;
      RS_ACK:  rs_next = RS_IDLE;
      default: rs_next = RS_IDLE;
    endcase
  end

  assign reseed_ack = (rs_state == RS_ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel      <= '0;
      div      <= '0;
      noise    <= '0;
      rs_state <= RS_IDLE;
      for (int unsigned v = 0; v < NCH; v++) begin
        count[v] <= '0;
        poly[v]  <= '0;
      end
    end else begin
      rs_state <= rs_next;
      if (cen) begin
        sel <= (sel == SW'(NCH-1)) ? '0 : sel + SW'(1);
        for (int unsigned v = 0; v < NCH; v++) begin
          if (sel == SW'(v)) begin
            count[v] <= nx_count;
            div[v]   <= nx_div;
            poly[v]  <= nx_poly;
            noise[v] <= nx_noise;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jt49_noise_sched.sv
// Self-checking bench for jt49_noise_sched against a slot-level reference model.
module tb_jt49_noise_sched;
  import jt49_pkg::*;

  localparam int NCH = 3;
  localparam int SW  = $clog2(NCH);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cen = 1'b0;
  logic [5*NCH-1:0] period = '0;
  logic             reseed_req = 1'b0;
  logic [SW-1:0]    reseed_voice = '0;
  logic             reseed_ack;
  logic [NCH-1:0]   noise;

  int total = 0;
  int bad   = 0;

  int             m_sel;
  int             m_cnt  [NCH];
  int             m_div  [NCH];
  int             m_poly [NCH];
  logic [NCH-1:0] m_noise;
  logic           m_ack;

  jt49_noise_sched #(.NCH(NCH)) dut (
    .clk          (clk),
    .rst          (rst),
    .cen          (cen),
    .period       (period),
    .reseed_req   (reseed_req),
    .reseed_voice (reseed_voice),
    .reseed_ack   (reseed_ack),
    .noise        (noise)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int lfsr_next(int p);
    int fb;
    fb = (p & 1) ^ ((p >> 3) & 1) ^ ((p == 0) ? 1 : 0);
    return (p >> 1) | (fb << 16);
  endfunction

  function automatic int eff_period(int v);
    int p;
    p = int'(period[5*v +: 5]);
    return (p == 0) ? 1 : p;
  endfunction

  task automatic model_edge();
    int v;
    bit inrange, hit, nack;
    nack = 1'b0;
    if (rst) begin
      m_sel = 0;
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0; m_div[i] = 0; m_poly[i] = 0;
      end
      m_noise = '0;
      m_ack   = 1'b0;
    end else begin
      if (cen) begin
        v       = m_sel;
        inrange = int'(reseed_voice) < NCH;
        hit     = reseed_req && !m_ack && (!inrange || int'(reseed_voice) == v);
        m_noise[v] = ((m_poly[v] & 1) == 0);
        if (hit && inrange) begin
          m_cnt[v] = 0; m_div[v] = 0; m_poly[v] = 0;
        end else begin
          m_cnt[v] = m_cnt[v] + 1;
          if (m_cnt[v] >= eff_period(v)) begin
            m_cnt[v] = 0;
            m_div[v] = 1 - m_div[v];
            if (m_div[v] == 1) m_poly[v] = lfsr_next(m_poly[v]);
          end
        end
        m_sel = (m_sel + 1) % NCH;
        nack  = hit;
      end
      m_ack = nack;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cen = 1'b0; reseed_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    period = {NCH{5'd1}};
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    total++; if (noise !== '0) begin bad++; $display("FAIL reset_noise: got %b want 000", noise); end
    total++; if (reseed_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", reseed_ack); end
    total++; if (dut.sel !== '0) begin bad++; $display("FAIL reset_sel: got %0d want 0", dut.sel); end
    cen = 1'b1;
    repeat (3) tick();
    total++; if (noise !== 3'b111) begin bad++; $display("FAIL first_noise: got %b want 111", noise); end
    tick();
    total++; if (dut.poly[0] !== 17'h10000) begin bad++; $display("FAIL poly0_cen4: got %h want 10000", dut.poly[0]); end
    cen = 1'b0;
  endtask

  task automatic test_random();
    int ncen;
    do_reset();
    for (int v = 0; v < NCH; v++) period[5*v +: 5] = 5'($urandom_range(0, 4));
    ncen = 0;
    while (ncen < 10000) begin
      cen = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0)
        period[5*$urandom_range(0, NCH-1) +: 5] = 5'($urandom_range(0, 31));
      tick();
      if (cen) ncen++;
      total++;
      if (noise !== m_noise || dut.sel !== SW'(m_sel) || reseed_ack !== 1'b0) begin
        bad++;
        $display("FAIL random_cycle: got noise=%b sel=%0d ack=%b want noise=%b sel=%0d ack=0",
                 noise, dut.sel, reseed_ack, m_noise, m_sel);
      end
    end
    for (int v = 0; v < NCH; v++) begin
      total++;
      if (dut.poly[v] !== 17'(m_poly[v])) begin
        bad++; $display("FAIL random_poly%0d: got %h want %h", v, dut.poly[v], 17'(m_poly[v]));
      end
    end
    cen = 1'b0;
  endtask

  task automatic test_period_zero();
    logic q0[$], q1[$];
    int   last_step, prev;
    logic [16:0] pp;
    for (int run = 0; run < 2; run++) begin
      period = {5'd1, (run == 0) ? 5'd0 : 5'd1, 5'd1};
      do_reset();
      cen = 1'b1;
      last_step = -1;
      pp = '0;
      for (int i = 1; i <= 60; i++) begin
        tick();
        if (run == 0) q0.push_back(noise[1]); else q1.push_back(noise[1]);
        if (dut.poly[1] !== pp) begin
          if (last_step >= 0 && run == 0) begin
            prev = i - last_step;
            total++;
            if (prev != 6) begin bad++; $display("FAIL v1_step_interval: got %0d want 6", prev); end
          end
          last_step = i;
          pp = dut.poly[1];
        end
        total++;
        if (noise !== m_noise) begin bad++; $display("FAIL pzero_noise: got %b want %b", noise, m_noise); end
      end
    end
    for (int i = 0; i < 60; i++) begin
      total++;
      if (q0[i] !== q1[i]) begin bad++; $display("FAIL pzero_vs_p1[%0d]: got %b want %b", i, q0[i], q1[i]); end
    end
    cen = 1'b0;
  endtask

  task automatic test_period_shrink();
    int  guard, toggles;
    logic d0, dprev;
    period = {5'd20, 5'd1, 5'd1};
    do_reset();
    cen = 1'b1;
    guard = 0;
    while (dut.count[2] !== 5'd15 && guard < 200) begin tick(); guard++; end
    total++;
    if (guard >= 200) begin bad++; $display("FAIL shrink_reach15: got count=%0d want 15", dut.count[2]); end
    d0 = dut.div[2];
    period[10 +: 5] = 5'd4;
    repeat (NCH) tick();
    total++; if (dut.count[2] !== 5'd0) begin bad++; $display("FAIL shrink_count: got %0d want 0", dut.count[2]); end
    total++; if (dut.div[2] !== ~d0) begin bad++; $display("FAIL shrink_div: got %b want %b", dut.div[2], ~d0); end
    toggles = 0;
    dprev = dut.div[2];
    repeat (8*NCH) begin
      tick();
      if (dut.div[2] !== dprev) toggles++;
      dprev = dut.div[2];
      total++;
      if (noise !== m_noise) begin bad++; $display("FAIL shrink_noise: got %b want %b", noise, m_noise); end
    end
    total++; if (toggles != 2) begin bad++; $display("FAIL shrink_rate: got %0d toggles want 2", toggles); end
    cen = 1'b0;
  endtask

  task automatic test_reseed();
    int lat, guard;
    for (int v = 0; v < NCH; v++) period[5*v +: 5] = 5'($urandom_range(1, 3));
    do_reset();
    cen = 1'b1;
    repeat (500) tick();
    reseed_req = 1'b1; reseed_voice = SW'(1);
    lat = 0;
    while (reseed_ack !== 1'b1 && lat < NCH + 1) begin tick(); lat++; end
    reseed_req = 1'b0;
    total++;
    if (reseed_ack !== 1'b1) begin bad++; $display("FAIL reseed_ack_latency: got no ack after %0d clk want <= %0d", lat, NCH+1); end
    total++; if (dut.poly[1] !== '0) begin bad++; $display("FAIL reseed_poly: got %h want 0", dut.poly[1]); end
    guard = 0;
    while (dut.poly[1] === '0 && guard < 20) begin
      tick(); guard++;
      total++;
      if (noise !== m_noise || reseed_ack !== m_ack) begin
        bad++; $display("FAIL reseed_track: got %b/%b want %b/%b", noise, reseed_ack, m_noise, m_ack);
      end
    end
    total++; if (dut.poly[1] !== 17'h10000) begin bad++; $display("FAIL reseed_restart: got %h want 10000", dut.poly[1]); end
    for (int v = 0; v < NCH; v += 2) begin
      total++;
      if (dut.poly[v] !== 17'(m_poly[v])) begin bad++; $display("FAIL reseed_other%0d: got %h want %h", v, dut.poly[v], 17'(m_poly[v])); end
    end
    cen = 1'b0;
  endtask

  task automatic test_reseed_collision();
    int guard;
    period = {NCH{5'd1}};
    do_reset();
    cen = 1'b1;
    repeat (7) tick();
    guard = 0;
    while (!(m_sel == 0 && m_div[0] == 0) && guard < 20) begin tick(); guard++; end
    reseed_req = 1'b1; reseed_voice = '0;
    tick();
    reseed_req = 1'b0;
    total++; if (reseed_ack !== 1'b1) begin bad++; $display("FAIL collide_ack: got %b want 1", reseed_ack); end
    total++; if (dut.poly[0] !== '0) begin bad++; $display("FAIL collide_poly: got %h want 0", dut.poly[0]); end
    total++; if (dut.div[0] !== 1'b0) begin bad++; $display("FAIL collide_div: got %b want 0", dut.div[0]); end
    tick();
    reseed_req = 1'b1; reseed_voice = '1;
    tick();
    reseed_req = 1'b0;
    total++; if (reseed_ack !== 1'b1) begin bad++; $display("FAIL oob_ack: got %b want 1", reseed_ack); end
    for (int v = 0; v < NCH; v++) begin
      total++;
      if (dut.poly[v] !== 17'(m_poly[v]) || dut.count[v] !== 5'(m_cnt[v])) begin
        bad++; $display("FAIL oob_state%0d: got %h/%0d want %h/%0d", v, dut.poly[v], dut.count[v], 17'(m_poly[v]), m_cnt[v]);
      end
    end
    tick();
    total++; if (reseed_ack !== 1'b0) begin bad++; $display("FAIL ack_width: got %b want 0", reseed_ack); end
    cen = 1'b0;
  endtask

  task automatic test_cen_hold();
    logic [NCH-1:0] snap_n;
    logic [SW-1:0]  snap_s;
    logic [NCH-1:0] qa[$], qb[$];
    period = {5'd2, 5'd1, 5'd3};
    do_reset();
    cen = 1'b1;
    repeat (37) tick();
    cen = 1'b0;
    snap_n = noise; snap_s = dut.sel;
    repeat (100) begin
      tick();
      total++;
      if (noise !== snap_n || dut.sel !== snap_s) begin
        bad++; $display("FAIL hold: got %b/%0d want %b/%0d", noise, dut.sel, snap_n, snap_s);
      end
    end
    cen = 1'b1;
    for (int run = 0; run < 2; run++) begin
      repeat (11) tick();
      reseed_req = 1'b1; reseed_voice = SW'(2);
      rst = 1'b1;
      tick();
      rst = 1'b0; reseed_req = 1'b0;
      total++;
      if (noise !== '0 || reseed_ack !== 1'b0) begin
        bad++; $display("FAIL midrst: got %b/%b want 000/0", noise, reseed_ack);
      end
      repeat (40) begin
        tick();
        if (run == 0) qa.push_back(noise); else qb.push_back(noise);
      end
    end
    for (int i = 0; i < 40; i++) begin
      total++;
      if (qa[i] !== qb[i]) begin bad++; $display("FAIL restart_seq[%0d]: got %b want %b", i, qb[i], qa[i]); end
    end
    cen = 1'b0;
  endtask

  initial begin
    test_reset();
    test_random();
    test_period_zero();
    test_period_shrink();
    test_reseed();
    test_reseed_collision();
    test_cen_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
